// File: rtl/parking_occupancy_controller_if.sv
// Sensor and status bundle for the parking occupancy controller.
// The master side drives the entry/exit sensors and observes the lot state.
// The slave side is the controller itself.
interface parking_occupancy_controller_if #(
    parameter int WIDTH = 4
);
    logic             entry_req;
    logic             exit_req;
    logic [WIDTH-1:0] count;
    logic             full;
    logic             empty;
    logic             gate_in;
    logic             gate_out;
    logic             op_valid;
    logic             op_sub;
    logic             reject;

    modport master (
        output entry_req,
        output exit_req,
        input  count,
        input  full,
        input  empty,
        input  gate_in,
        input  gate_out,
        input  op_valid,
        input  op_sub,
        input  reject
    );

    modport slave (
        input  entry_req,
        input  exit_req,
        output count,
        output full,
        output empty,
        output gate_in,
        output gate_out,
        output op_valid,
        output op_sub,
        output reject
    );
endinterface

// File: rtl/parking_occupancy_controller.sv
// Parking lot occupancy controller.
// A gate FSM serves one car per IDLE visit. Exits take priority over entries.
// Each accepted car produces a one-cycle op_valid/op_sub command. That command
// feeds a saturating add/subtract stage, which updates count one cycle later.
// A car must clear its sensor before the FSM re-arms, so no car is counted twice.
module parking_occupancy_controller #(
    parameter int WIDTH       = 4,
    parameter int CAPACITY    = 15,
    parameter int GATE_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    parking_occupancy_controller_if.slave bus
);

    localparam int HOLD_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD_C = HOLD_W'(GATE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO_C = {HOLD_W{1'b0}};
    localparam logic [WIDTH-1:0]  CAP_C       = WIDTH'(CAPACITY);
    localparam logic [WIDTH-1:0]  ZERO_C      = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ENTRY_OPEN = 2'd1,
        ST_EXIT_OPEN  = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } state_t;

    state_t             state_r;
    logic [HOLD_W-1:0]  hold_r;
    logic               dir_exit_r;   // direction being served: 1 = exit, 0 = entry
    logic               armed_r;      // reject may fire for the current entry request
    logic               gate_in_r;
    logic               gate_out_r;
    logic               op_valid_r;
    logic               op_sub_r;
    logic               reject_r;
    logic [WIDTH-1:0]   count_r;
    logic               full_s;
    logic               empty_s;

    // full/empty are decoded straight from the registered count
    assign full_s  = (count_r == CAP_C);
    assign empty_s = (count_r == ZERO_C);

    assign bus.count    = count_r;
    assign bus.full     = full_s;
    assign bus.empty    = empty_s;
    assign bus.gate_in  = gate_in_r;
    assign bus.gate_out = gate_out_r;
    assign bus.op_valid = op_valid_r;
    assign bus.op_sub   = op_sub_r;
    assign bus.reject   = reject_r;

    // Gate FSM with hold counter, registered gate commands and one-cycle pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            hold_r     <= HOLD_ZERO_C;
            dir_exit_r <= 1'b0;
            armed_r    <= 1'b1;
            gate_in_r  <= 1'b0;
            gate_out_r <= 1'b0;
            op_valid_r <= 1'b0;
            op_sub_r   <= 1'b0;
            reject_r   <= 1'b0;
        end else begin
            op_valid_r <= 1'b0;
            op_sub_r   <= 1'b0;
            reject_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!bus.entry_req) begin
                        armed_r <= 1'b1;
                    end
                    if (bus.exit_req && !empty_s) begin
                        state_r    <= ST_EXIT_OPEN;
                        hold_r     <= HOLD_LOAD_C;
                        dir_exit_r <= 1'b1;
                        gate_out_r <= 1'b1;
                        op_valid_r <= 1'b1;
                        op_sub_r   <= 1'b1;
                    end else if (bus.entry_req && !full_s) begin
                        state_r    <= ST_ENTRY_OPEN;
                        hold_r     <= HOLD_LOAD_C;
                        dir_exit_r <= 1'b0;
                        gate_in_r  <= 1'b1;
                        op_valid_r <= 1'b1;
                    end else if (bus.entry_req && full_s && armed_r) begin
                        reject_r <= 1'b1;
                        armed_r  <= 1'b0;
                    end
                end
                ST_ENTRY_OPEN: begin
                    if (hold_r == HOLD_ZERO_C) begin
                        state_r   <= ST_WAIT_CLEAR;
                        gate_in_r <= 1'b0;
                    end else begin
                        hold_r <= hold_r - HOLD_W'(1);
                    end
                end
                ST_EXIT_OPEN: begin
                    if (hold_r == HOLD_ZERO_C) begin
                        state_r    <= ST_WAIT_CLEAR;
                        gate_out_r <= 1'b0;
                    end else begin
                        hold_r <= hold_r - HOLD_W'(1);
                    end
                end
                ST_WAIT_CLEAR: begin
                    if (!bus.entry_req) begin
                        armed_r <= 1'b1;
                    end
                    if ((dir_exit_r && !bus.exit_req) || (!dir_exit_r && !bus.entry_req)) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    hold_r     <= HOLD_ZERO_C;
                    gate_in_r  <= 1'b0;
                    gate_out_r <= 1'b0;
                end
            endcase
        end
    end

    // Add/subtract stage that applies the accepted operation and never wraps
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= ZERO_C;
        end else if (op_valid_r && op_sub_r && (count_r != ZERO_C)) begin
            count_r <= count_r - WIDTH'(1);
        end else if (op_valid_r && !op_sub_r && (count_r != CAP_C)) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: tb/tb_parking_occupancy_controller.sv
// Directed self-checking bench for parking_occupancy_controller (default parameters).
module tb_parking_occupancy_controller;

    logic clk;
    logic reset;
    int   total_cnt;
    int   bad_cnt;
    int   ov_n;
    int   gi_n;
    int   go_n;
    int   rej_n;
    int   wait_n;

    parking_occupancy_controller_if #(.WIDTH(4)) bus ();

    parking_occupancy_controller #(
        .WIDTH(4),
        .CAPACITY(15),
        .GATE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one entering car that leaves the sensor right after being accepted
    task automatic car_in;
        bus.entry_req = 1'b1;
        tick();
        bus.entry_req = 1'b0;
        repeat (7) tick();
    endtask

    // one exiting car that leaves the sensor right after being accepted
    task automatic car_out;
        bus.exit_req = 1'b1;
        tick();
        bus.exit_req = 1'b0;
        repeat (7) tick();
    endtask

    // directed scenario sequence
    initial begin
        total_cnt     = 0;
        bad_cnt       = 0;
        reset         = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        tick();
        tick();

        // reset state
        check_val("rst_count",    32'(bus.count),    32'd0);
        check_val("rst_full",     32'(bus.full),     32'd0);
        check_val("rst_empty",    32'(bus.empty),    32'd1);
        check_val("rst_gate_in",  32'(bus.gate_in),  32'd0);
        check_val("rst_gate_out", 32'(bus.gate_out), 32'd0);
        check_val("rst_op_valid", 32'(bus.op_valid), 32'd0);
        check_val("rst_op_sub",   32'(bus.op_sub),   32'd0);
        check_val("rst_reject",   32'(bus.reject),   32'd0);
        reset = 1'b0;
        tick();

        // single entry with the sensor held for 20 cycles
        bus.entry_req = 1'b1;
        tick();
        check_val("ent_op_valid", 32'(bus.op_valid), 32'd1);
        check_val("ent_op_sub",   32'(bus.op_sub),   32'd0);
        check_val("ent_gate_in",  32'(bus.gate_in),  32'd1);
        check_val("ent_count_lat", 32'(bus.count),   32'd0);
        ov_n = int'(bus.op_valid);
        gi_n = int'(bus.gate_in);
        tick();
        check_val("ent_count_next", 32'(bus.count), 32'd1);
        ov_n += int'(bus.op_valid);
        gi_n += int'(bus.gate_in);
        for (int i = 0; i < 18; i++) begin
            tick();
            ov_n += int'(bus.op_valid);
            gi_n += int'(bus.gate_in);
        end
        check_val("held_op_pulses", 32'(ov_n), 32'd1);
        check_val("gate_in_cycles", 32'(gi_n), 32'd4);
        check_val("held_count",     32'(bus.count), 32'd1);
        bus.entry_req = 1'b0;
        repeat (2) tick();
        check_val("after_clear_count",   32'(bus.count),   32'd1);
        check_val("after_clear_gate_in", 32'(bus.gate_in), 32'd0);

        // fill the lot up to capacity
        for (int i = 0; i < 14; i++) begin
            car_in();
        end
        check_val("fill_count", 32'(bus.count), 32'd15);
        check_val("fill_full",  32'(bus.full),  32'd1);
        check_val("fill_empty", 32'(bus.empty), 32'd0);

        // 16th car is refused once while the request persists
        bus.entry_req = 1'b1;
        rej_n = 0;
        gi_n  = 0;
        ov_n  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            rej_n += int'(bus.reject);
            gi_n  += int'(bus.gate_in);
            ov_n  += int'(bus.op_valid);
        end
        check_val("full_reject_pulses", 32'(rej_n), 32'd1);
        check_val("full_gate_in",       32'(gi_n),  32'd0);
        check_val("full_op_valid",      32'(ov_n),  32'd0);
        check_val("full_count",         32'(bus.count), 32'd15);
        bus.entry_req = 1'b0;
        tick();
        bus.entry_req = 1'b1;
        tick();
        check_val("reject_rearm", 32'(bus.reject), 32'd1);
        bus.entry_req = 1'b0;
        tick();

        // drain to 3 cars, then simultaneous entry and exit
        for (int i = 0; i < 12; i++) begin
            car_out();
        end
        check_val("drain_count", 32'(bus.count), 32'd3);
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        tick();
        check_val("both_first_op_valid", 32'(bus.op_valid), 32'd1);
        check_val("both_first_op_sub",   32'(bus.op_sub),   32'd1);
        check_val("both_first_gate_out", 32'(bus.gate_out), 32'd1);
        check_val("both_first_gate_in",  32'(bus.gate_in),  32'd0);
        bus.exit_req = 1'b0;
        tick();
        check_val("both_exit_count", 32'(bus.count), 32'd2);
        wait_n = 0;
        do begin
            tick();
            wait_n++;
        end while (!bus.op_valid && wait_n < 20);
        check_val("pending_entry_latency", 32'(wait_n), 32'd5);
        check_val("pending_entry_op_sub",  32'(bus.op_sub),  32'd0);
        check_val("pending_entry_gate_in", 32'(bus.gate_in), 32'd1);
        tick();
        check_val("pending_entry_count", 32'(bus.count), 32'd3);
        bus.entry_req = 1'b0;
        repeat (10) tick();

        // exit request on an empty lot is ignored
        for (int i = 0; i < 3; i++) begin
            car_out();
        end
        check_val("empty_flag", 32'(bus.empty), 32'd1);
        bus.exit_req = 1'b1;
        ov_n = 0;
        go_n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ov_n += int'(bus.op_valid);
            go_n += int'(bus.gate_out);
        end
        check_val("empty_exit_op_valid", 32'(ov_n), 32'd0);
        check_val("empty_exit_gate_out", 32'(go_n), 32'd0);
        check_val("empty_exit_count",    32'(bus.count), 32'd0);
        bus.exit_req = 1'b0;
        tick();

        // reset during the second cycle of an open exit gate
        car_in();
        check_val("pre_exit_count", 32'(bus.count), 32'd1);
        bus.exit_req = 1'b1;
        tick();
        bus.exit_req = 1'b0;
        tick();
        check_val("exit_open_gate_out", 32'(bus.gate_out), 32'd1);
        reset = 1'b1;
        tick();
        check_val("midrst_gate_out", 32'(bus.gate_out), 32'd0);
        check_val("midrst_op_valid", 32'(bus.op_valid), 32'd0);
        check_val("midrst_count",    32'(bus.count),    32'd0);
        check_val("midrst_empty",    32'(bus.empty),    32'd1);
        reset = 1'b0;
        bus.entry_req = 1'b1;
        tick();
        check_val("midrst_idle_entry", 32'(bus.op_valid), 32'd1);
        bus.entry_req = 1'b0;
        repeat (8) tick();
        check_val("midrst_final_count", 32'(bus.count), 32'd1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
